// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state
// encoding and the primary opcode values the decoder keys on.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int unsigned INSTR_W = 32;

    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC adder: sequential PC+4, optionally plus the sign-extended word offset
// of a taken branch. Wraps modulo 2^ADDR_W and keeps the result word aligned.
module fetch_pc_next #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm16,
    input  logic              take,
    output logic [ADDR_W-1:0] next_pc
);

    logic signed [15:0]       imm_s;
    logic signed [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0]        seq_pc;
    logic [ADDR_W-1:0]        branch_off;
    logic [ADDR_W-1:0]        sum;

    assign imm_s  = imm16;
    // The size cast sign-extends, the shift turns the word offset into bytes.
    assign offset = ADDR_W'(imm_s) <<< 2;

    assign seq_pc     = pc + ADDR_W'(4);
    assign branch_off = take ? $unsigned(offset) : '0;
    assign sum        = seq_pc + branch_off;
    assign next_pc    = {sum[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word from instruction memory, holds it
// for the decoder until consumed, then advances the PC (sequential or branch).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr_word,
    output logic [5:0]        instr_op,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              stall,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [31:0]       retired_cnt
);

    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next_d;
    logic [31:0]       instr_word_q;
    logic [31:0]       retired_cnt_q;
    logic              req_q;
    logic              valid_q;
    logic              consume_d;
    logic              take_d;

    // Branch inputs only matter in the cycle the held instruction is consumed.
    assign consume_d = (state_q == HOLD) && !stall;
    assign take_d    = consume_d && branch && alu_zero;

    fetch_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc      (pc_q),
        .imm16   (instr_word_q[15:0]),
        .take    (take_d),
        .next_pc (pc_next_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_word_q  <= '0;
            retired_cnt_q <= '0;
            req_q         <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        instr_word_q <= imem_rdata;
                        state_q      <= HOLD;
                        req_q        <= 1'b0;
                        valid_q      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (consume_d) begin
                        pc_q          <= pc_next_d;
                        retired_cnt_q <= retired_cnt_q + 32'd1;
                        state_q       <= FETCH;
                        req_q         <= 1'b1;
                        valid_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Qualify with rst_n so request/valid drop in the very cycle reset is asserted.
    assign imem_req    = req_q & rst_n;
    assign instr_valid = valid_q & rst_n;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr_word  = instr_word_q;
    assign instr_op    = opcode_of(instr_word_q);
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transaction-level model checked every cycle.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [5:0]  instr_op;
    logic [31:0] pc_out;
    logic        stall;
    logic        branch;
    logic        alu_zero;
    logic [31:0] retired_cnt;

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_word  (instr_word),
        .instr_op    (instr_op),
        .pc_out      (pc_out),
        .stall       (stall),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Instruction memory: 32 words at 0x00..0x7C, a fixed pattern elsewhere.
    logic [31:0] mem_arr [0:31];
    int          wait_states;
    int          wcnt;
    logic        force_rvalid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h80) return mem_arr[a[6:2]];
        return {6'h23, a[25:0]};
    endfunction

    always @(posedge clk) wcnt <= (imem_req && !imem_rvalid) ? wcnt + 1 : 0;
    assign imem_rvalid = (imem_req && (wcnt >= wait_states)) || force_rvalid;
    assign imem_rdata  = !imem_req ? 32'hDEAD_BEEF :
                         (imem_addr < 32'h80) ? mem_arr[imem_addr[6:2]] : {6'h23, imem_addr[25:0]};

    // Behavioural model: what the fetch stage must present, per cycle.
    typedef enum int {M_IDLE, M_FETCH, M_HOLD} mph_t;
    mph_t              m_phase;
    logic [31:0]       m_pc;
    logic [31:0]       m_word;
    logic [31:0]       m_cnt;
    logic              model_on = 1'b0;
    logic signed [15:0] m_imm;
    logic signed [31:0] m_off;
    logic [31:0]       fetched [$];

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_req", imem_req, rst_n && (m_phase == M_FETCH));
            if (rst_n && (m_phase == M_FETCH)) chk("m_addr", imem_addr, m_pc);
            chk("m_valid", instr_valid, rst_n && (m_phase == M_HOLD));
            if (rst_n && (m_phase == M_HOLD)) begin
                chk("m_word", instr_word, m_word);
                chk("m_pc_out", pc_out, m_pc);
                chk("m_op", instr_op, m_word[31:26]);
            end
            chk("m_cnt", retired_cnt, m_cnt);
        end
        if (imem_req && imem_rvalid) fetched.push_back(imem_addr);
        if (!rst_n) begin
            m_phase  = M_IDLE;
            m_pc     = 32'h0;
            m_word   = 32'h0;
            m_cnt    = 32'h0;
            model_on = 1'b1;
        end else begin
            case (m_phase)
                M_IDLE:  m_phase = M_FETCH;
                M_FETCH: if (imem_rvalid) begin
                    m_word  = mem_word(m_pc);
                    m_phase = M_HOLD;
                end
                M_HOLD: if (!stall) begin
                    m_imm = m_word[15:0];
                    m_off = m_imm;
                    m_off = m_off * 4;
                    if (branch && alu_zero) m_pc = m_pc + 32'd4 + m_off;
                    else                    m_pc = m_pc + 32'd4;
                    m_cnt   = m_cnt + 32'd1;
                    m_phase = M_FETCH;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    task automatic wait_hold(input logic [31:0] exp_pc);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!instr_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_reached", instr_valid, 1'b1);
        chk("hold_pc", pc_out, exp_pc);
    endtask

    // Consume the held instruction in a single HOLD cycle; returns in the next FETCH cycle.
    task automatic consume(input logic [31:0] exp_pc, input logic br, input logic z);
        wait_hold(exp_pc);
        stall    = 1'b0;
        branch   = br;
        alu_zero = z;
        @(posedge clk); #1;
        stall    = 1'b1;
        branch   = 1'b0;
        alu_zero = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem_arr[i] = 32'h0000_0020 | (i << 11);
        mem_arr[0] = 32'h1000_FFFE;   // BEQ, offset -2 words
        mem_arr[1] = 32'h1000_000E;   // BEQ, offset +14 words
        mem_arr[2] = 32'h8C22_0008;   // LW
        mem_arr[3] = 32'hAC43_000C;   // SW
        mem_arr[4] = 32'h1000_FFFF;   // BEQ, offset -1 word
        mem_arr[5] = 32'h1000_0100;   // BEQ, offset +256 words
        wait_states  = 0;
        force_rvalid = 1'b0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        alu_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset release, zero wait states, free-running consumption.
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_cnt", retired_cnt, 32'h0);
        rst_n = 1'b1;
        @(negedge clk); chk("rel_c1_req", imem_req, 1'b0);
        @(negedge clk); chk("rel_c2_req", imem_req, 1'b1);
                        chk("rel_c2_addr", imem_addr, 32'h0);
        @(negedge clk); chk("rel_c3_valid", instr_valid, 1'b1);
        n = 0;
        while (retired_cnt != 32'd3 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        stall = 1'b1;
        chk("seq_cnt3", retired_cnt, 32'd3);
        chk("seq_nfetch", fetched.size() >= 3, 1'b1);
        if (fetched.size() >= 3) begin
            chk("seq_addr0", fetched[0], 32'h0);
            chk("seq_addr1", fetched[1], 32'h4);
            chk("seq_addr2", fetched[2], 32'h8);
        end

        // Branch taken / not taken from PC 0x10.
        consume(32'hC, 1'b0, 1'b0);
        chk("pc_0c_next", imem_addr, 32'h10);
        consume(32'h10, 1'b1, 1'b1);
        chk("beq_taken_addr", imem_addr, 32'h10);
        consume(32'h10, 1'b1, 1'b0);
        chk("beq_not_taken_addr", imem_addr, 32'h14);

        // Stall in HOLD, with stray rvalid and branch activity that must be ignored.
        wait_hold(32'h14);
        force_rvalid = 1'b1;
        branch       = 1'b1;
        alu_zero     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_word", instr_word, 32'h1000_0100);
            chk("stall_pc", pc_out, 32'h14);
            chk("stall_req", imem_req, 1'b0);
            chk("stall_cnt", retired_cnt, 32'd6);
        end
        @(posedge clk); #1;
        force_rvalid = 1'b0;
        branch       = 1'b0;
        alu_zero     = 1'b0;
        consume(32'h14, 1'b0, 1'b0);
        chk("after_stall_addr", imem_addr, 32'h18);
        chk("after_stall_cnt", retired_cnt, 32'd7);

        // Reset mid-FETCH, then branch backwards to the top of the address space.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst2_cnt", retired_cnt, 32'h0);
        consume(32'h0, 1'b1, 1'b1);
        chk("wrap_branch_addr", imem_addr, 32'hFFFF_FFFC);
        consume(32'hFFFF_FFFC, 1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_cnt", retired_cnt, 32'd2);

        // Wait states, forward branch to 0x40, then reset while that fetch is pending.
        wait_states = 2;
        consume(32'h0, 1'b0, 1'b0);
        chk("ws_addr4", imem_addr, 32'h4);
        consume(32'h4, 1'b1, 1'b1);
        chk("fwd_addr", imem_addr, 32'h40);
        chk("fwd_req", imem_req, 1'b1);
        chk("fwd_cnt", retired_cnt, 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        wait_states = 0;
        chk("midrst_cnt", retired_cnt, 32'h0);
        @(negedge clk); chk("refetch_idle_req", imem_req, 1'b0);
        @(negedge clk); chk("refetch_req", imem_req, 1'b1);
                        chk("refetch_addr", imem_addr, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, ADDR_W, word-aligned fetch address.
REQ-007 SHALL have port imem_rvalid, input, 1, read data valid from memory.
REQ-008 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-009 SHALL have port instr_valid, output, 1, held instruction available to the decoder.
REQ-010 SHALL have port instr_word, output, 32, held instruction.
REQ-011 SHALL have port instr_op, output, 6, instr_word[31:26], driving the decoder opcode input.
REQ-012 SHALL have port pc_out, output, ADDR_W, address of the held instruction.
REQ-013 SHALL have port stall, input, 1, downstream not ready; holds the current instruction.
REQ-014 SHALL have port branch, input, 1, decoder branch control for the held instruction.
REQ-015 SHALL have port alu_zero, input, 1, ALU equality result for the held instruction.
REQ-016 SHALL have port retired_cnt, output, 32, count of consumed instructions.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-018 IDLE SHALL move to FETCH unconditionally on the next cycle.
REQ-019 FETCH SHALL assert imem_req with imem_addr = PC every cycle until imem_rvalid is 1.
REQ-020 FETCH with imem_rvalid=1 SHALL capture imem_rdata into instr_word and enter HOLD; instr_valid rises the next cycle.
REQ-021 HOLD SHALL keep instr_valid=1 and instr_word/pc_out stable while stall=1.
REQ-022 HOLD with stall=0 SHALL consume: update PC, increment retired_cnt, and enter FETCH; instr_valid drops the next cycle.
REQ-023 Next PC on consume SHALL be PC+4 when (branch & alu_zero)=0.
REQ-024 Next PC on consume SHALL be PC+4 + (sign-extended instr_word[15:0] << 2) when (branch & alu_zero)=1.
REQ-025 PC arithmetic SHALL be modulo 2^ADDR_W, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-026 PC[1:0] SHALL always be 2'b00.
REQ-027 imem_rvalid outside FETCH SHALL be ignored.
REQ-028 branch and alu_zero SHALL be ignored unless a consume occurs in that same cycle.
REQ-029 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 Minimum fetch-to-consume latency SHALL be: 1 cycle in FETCH with rvalid, then 1 cycle in HOLD with stall=0; steady state is one instruction per 2 cycles.

Reset
REQ-031 With rst_n=0 at a rising edge, the FSM SHALL go to IDLE, PC SHALL be RESET_PC, instr_word SHALL be 0, and retired_cnt SHALL be 0.
REQ-032 During reset, imem_req and instr_valid SHALL be 0.
REQ-033 Reset SHALL abort an in-flight FETCH or HOLD with no PC update and no count increment.
REQ-034 The instruction memory SHALL be reset together with this block, so no stale rvalid arrives after reset.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef and the opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04.
REQ-036 Next-PC computation SHALL be one combinational sub-module, fetch_pc_next (inputs pc, imm16, take; output next_pc).

Verification
REQ-037 Reset release with RESET_PC=0 and rvalid returned on the first req cycle -> imem_addr=0; instr_valid=1 on the third cycle after reset release.
REQ-038 Three sequential instructions, stall=0, memory with 0 wait states -> fetch addresses 0, 4, 8; retired_cnt=3.
REQ-039 BEQ 32'h1000_FFFF at PC=0x10 with branch=1, alu_zero=1 -> next imem_addr=0x10; with alu_zero=0 -> next imem_addr=0x14.
REQ-040 stall held for 5 cycles in HOLD -> instr_word/pc_out unchanged, imem_req=0, retired_cnt unchanged.
REQ-041 PC=0xFFFF_FFFC consumed with no branch -> next imem_addr=0x0000_0000.
REQ-042 rst_n=0 for one cycle mid-FETCH at PC=0x40 -> imem_req=0 that cycle, then refetch from RESET_PC; retired_cnt=0.
